// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: CLK_in divider with /2, /10, /100 or programmable 2*N ratio.
// Ratio changes and stop requests only take effect at CLK_out falling edges.
module freq_div_ctrl #(
  parameter int         CNT_W    = 8,
  parameter logic [1:0] DEF_SEL  = 2'd0,
  parameter int         DEF_HALF = 1
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             CLK_out,
  output logic             edge_stb,
  output logic [1:0]       active_sel,
  output logic             busy,
  output logic             cfg_err
);

  if (CNT_W < 6) begin : g_cnt_w_chk
    $error("freq_div_ctrl: CNT_W must be >= 6");
  end

  if (DEF_HALF < 1) begin : g_def_half_chk
    $error("freq_div_ctrl: DEF_HALF must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_STOP
  } state_e;

  localparam logic [CNT_W-1:0] H1  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H5  = CNT_W'(5);
  localparam logic [CNT_W-1:0] H50 = CNT_W'(50);
  localparam logic [CNT_W-1:0] HDF = CNT_W'(DEF_HALF);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic               stb_q, stb_d;
  logic               err_q, err_d;
  logic [1:0]         asel_q, asel_d;
  logic [CNT_W-1:0]   ahalf_q, ahalf_d;
  logic [1:0]         ssel_q, ssel_d;
  logic [CNT_W-1:0]   shalf_q, shalf_d;
  logic               pend_q, pend_d;

  logic [CNT_W-1:0]   half;
  logic [CNT_W-1:0]   half_m1;
  logic [CNT_W-1:0]   cnt_nx;
  logic               clk_nx;
  logic               tgl;
  logic               fall;
  logic               hs;
  logic               bad;
  logic               good;
  logic               ld_sh;
  logic               ld_cfg;

  always_comb begin
    half = ahalf_q;
    unique case (1'b1)
      (asel_q == 2'd0): half = H1;
      (asel_q == 2'd1): half = H5;
      (asel_q == 2'd2): half = H50;
      default:          half = ahalf_q;
    endcase
  end

  assign half_m1 = half - H1;
  assign tgl     = (cnt_q == half_m1);
  assign fall    = tgl & clk_q;
  assign cnt_nx  = tgl ? '0 : cnt_q + H1;
  assign clk_nx  = clk_q ^ tgl;

  assign cfg_ready = (state_q == S_IDLE) | (state_q == S_RUN);
  assign hs        = cfg_valid & cfg_ready;
  assign bad       = (cfg_sel == 2'd3) & (cfg_half == '0);
  assign good      = hs & ~bad;
  assign err_d     = hs & bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    pend_d  = pend_q;
    ssel_d  = ssel_q;
    shalf_d = shalf_q;
    asel_d  = asel_q;
    ahalf_d = ahalf_q;
    ld_sh   = 1'b0;
    ld_cfg  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        ld_cfg = good;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_nx;
        clk_d = clk_nx;
        // Low phase (or a fall this edge) lets us stop without a runt
        if (!en && (!clk_q || fall)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
          ld_cfg  = good;
        end else begin
          if (good) begin
            ssel_d  = cfg_sel;
            shalf_d = cfg_half;
            pend_d  = 1'b1;
          end
          if (!en) begin
            state_d = S_STOP;
          end else if (good) begin
            state_d = S_PEND;
          end
        end
      end
      S_PEND: begin
        cnt_d = cnt_nx;
        clk_d = clk_nx;
        if (!en && (!clk_q || fall)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
          ld_sh   = 1'b1;
          pend_d  = 1'b0;
        end else if (!en) begin
          state_d = S_STOP;
        end else if (fall) begin
          state_d = S_RUN;
          cnt_d   = '0;
          ld_sh   = 1'b1;
          pend_d  = 1'b0;
        end
      end
      S_STOP: begin
        cnt_d = cnt_nx;
        clk_d = clk_nx;
        if (fall) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
          ld_sh   = pend_q;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ld_cfg) begin
      asel_d = cfg_sel;
      if (cfg_sel == 2'd3) ahalf_d = cfg_half;
    end
    if (ld_sh) begin
      asel_d = ssel_q;
      if (ssel_q == 2'd3) ahalf_d = shalf_q;
    end
  end

  assign stb_d = clk_d & ~clk_q;

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      asel_q  <= DEF_SEL;
      ahalf_q <= HDF;
      ssel_q  <= 2'd0;
      shalf_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      asel_q  <= asel_d;
      ahalf_q <= ahalf_d;
      ssel_q  <= ssel_d;
      shalf_q <= shalf_d;
      pend_q  <= pend_d;
    end
  end

  assign CLK_out    = clk_q;
  assign edge_stb   = stb_q;
  assign active_sel = asel_q;
  assign busy       = (state_q != S_IDLE);
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: period-position reference model compared every
// cycle, directed ratio/stop/reset scenarios, then randomized traffic.
module tb_freq_div_ctrl;

  localparam int CNT_W = 8;

  logic             CLK_in = 1'b0;
  logic             RST = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_sel = 2'd0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready;
  logic             CLK_out;
  logic             edge_stb;
  logic [1:0]       active_sel;
  logic             busy;
  logic             cfg_err;

  freq_div_ctrl #(
    .CNT_W(CNT_W),
    .DEF_SEL(2'd0),
    .DEF_HALF(1)
  ) dut (
    .CLK_in(CLK_in),
    .RST(RST),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel),
    .cfg_half(cfg_half),
    .CLK_out(CLK_out),
    .edge_stb(edge_stb),
    .active_sel(active_sel),
    .busy(busy),
    .cfg_err(cfg_err)
  );

  always #5 CLK_in = ~CLK_in;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts CLK_in edges since the current output period began;
  // CLK_out is high for the second half of each 2H-edge period.
  typedef struct {
    int busy;
    int pend;
    int stop;
    int t;
    int asel;
    int ahalf;
    int ssel;
    int shalf;
    bit clk;
    bit stb;
    bit err;
  } mdl_t;

  function automatic int hv(int s, int h);
    case (s)
      0: return 1;
      1: return 5;
      2: return 50;
      default: return h;
    endcase
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.busy = 0; r.pend = 0; r.stop = 0; r.t = 0;
    r.asel = 0; r.ahalf = 1; r.ssel = 0; r.shalf = 0;
    r.clk = 0; r.stb = 0; r.err = 0;
    return r;
  endfunction

  function automatic bit mready(mdl_t c);
    return (c.busy == 0) || (c.pend == 0 && c.stop == 0);
  endfunction

  function automatic mdl_t step(mdl_t c, bit e, bit v, int s, int h);
    mdl_t n;
    int hh, p, h2;
    bit cur, fall, hs, bad, good, oldp;
    n = c;
    hh = hv(c.asel, c.ahalf);
    p = 2 * hh;
    cur = (c.busy != 0) && ((c.t % p) >= hh);
    fall = cur && (((c.t + 1) % p) == 0);
    hs = v && mready(c);
    bad = (s == 3) && (h == 0);
    good = hs && !bad;
    n.err = hs && bad;
    if (c.busy == 0) begin
      if (good) begin
        n.asel = s;
        if (s == 3) n.ahalf = h;
      end
      if (e) begin
        n.busy = 1;
        n.t = 0;
      end
    end else begin
      oldp = (c.pend != 0);
      if (good) begin
        n.ssel = s; n.shalf = h; n.pend = 1;
      end
      n.t = (c.t + 1) % p;
      if (c.stop != 0 || !e) begin
        if (!cur || fall) begin
          n.busy = 0; n.stop = 0; n.t = 0;
          if (n.pend != 0) begin
            n.asel = n.ssel;
            if (n.ssel == 3) n.ahalf = n.shalf;
            n.pend = 0;
          end
        end else begin
          n.stop = 1;
        end
      end else if (fall && oldp) begin
        n.asel = n.ssel;
        if (n.ssel == 3) n.ahalf = n.shalf;
        n.pend = 0;
        n.t = 0;
      end
    end
    h2 = hv(n.asel, n.ahalf);
    n.clk = (n.busy != 0) && ((n.t % (2 * h2)) >= h2);
    n.stb = n.clk && !cur;
    return n;
  endfunction

  mdl_t m;
  bit cmp_on = 1'b0;

  always @(posedge CLK_in or posedge RST) begin
    if (RST) m <= mreset();
    else m <= step(m, en, cfg_valid, int'(cfg_sel), int'(cfg_half));
  end

  always @(negedge CLK_in) begin
    if (cmp_on) begin
      check("m_clk_out", CLK_out, m.clk);
      check("m_edge_stb", edge_stb, m.stb);
      check("m_active_sel", active_sel, m.asel);
      check("m_busy", busy, m.busy != 0);
      check("m_cfg_ready", cfg_ready, mready(m));
      check("m_cfg_err", cfg_err, m.err);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge CLK_in);
    check("wait_idle", busy, 0);
  endtask

  task automatic wait_rise();
    for (int i = 0; i < 400 && !edge_stb; i++) @(negedge CLK_in);
    check("wait_rise", edge_stb, 1);
  endtask

  // Entered on the first high negedge; leaves on the next rise.
  task automatic measure(output int hi, output int lo);
    hi = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_in);
      if (!CLK_out) break;
      hi++;
    end
    lo = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_in);
      if (CLK_out) break;
      lo++;
    end
  endtask

  task automatic offer(input logic [1:0] s, input logic [CNT_W-1:0] h);
    cfg_valid = 1'b1;
    cfg_sel = s;
    cfg_half = h;
  endtask

  int hi, lo, cnt;

  initial begin
    #23;
    check("rst_clk_out", CLK_out, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_active_sel", active_sel, 0);
    check("rst_edge_stb", edge_stb, 0);
    check("rst_cfg_err", cfg_err, 0);
    #4 RST = 1'b0;
    cmp_on = 1'b1;

    // Default /2
    @(negedge CLK_in);
    en = 1'b1;
    @(negedge CLK_in);
    check("div2_entry_busy", busy, 1);
    check("div2_entry_clk", CLK_out, 0);
    @(negedge CLK_in);
    check("div2_rise1", CLK_out, 1);
    check("div2_stb1", edge_stb, 1);
    @(negedge CLK_in);
    check("div2_low", CLK_out, 0);
    check("div2_stb_low", edge_stb, 0);
    @(negedge CLK_in);
    check("div2_rise2", edge_stb, 1);

    // /10 configured while idle
    en = 1'b0;
    wait_idle();
    offer(2'd1, '0);
    @(negedge CLK_in);
    cfg_valid = 1'b0;
    check("idle_cfg_sel1", active_sel, 1);
    en = 1'b1;
    wait_rise();
    measure(hi, lo);
    check("div10_high", hi, 5);
    check("div10_low", lo, 5);

    // Switch to /100 two cycles into a high phase
    @(negedge CLK_in);
    offer(2'd2, '0);
    @(negedge CLK_in);
    cfg_valid = 1'b0;
    check("pend_ready_low", cfg_ready, 0);
    check("pend_old_sel", active_sel, 1);
    hi = 3;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_in);
      if (!CLK_out) break;
      hi++;
    end
    check("pend_high_full", hi, 5);
    check("pend_switch_sel", active_sel, 2);
    check("pend_ready_back", cfg_ready, 1);
    lo = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_in);
      if (CLK_out) break;
      lo++;
    end
    check("div100_first_low", lo, 50);
    measure(hi, lo);
    check("div100_high", hi, 50);
    check("div100_low", lo, 50);

    // Stop request mid high phase
    repeat (10) @(negedge CLK_in);
    en = 1'b0;
    hi = 11;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_in);
      if (!CLK_out) break;
      hi++;
    end
    check("stop_high_full", hi, 50);
    check("stop_busy_low", busy, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge CLK_in);
      cnt += int'(CLK_out);
    end
    check("stop_stays_low", cnt, 0);

    // Rejected programmable config, then half=3
    en = 1'b1;
    offer(2'd3, '0);
    @(negedge CLK_in);
    cfg_valid = 1'b0;
    check("bad_cfg_err", cfg_err, 1);
    check("bad_cfg_sel", active_sel, 2);
    @(negedge CLK_in);
    check("bad_cfg_err_clr", cfg_err, 0);
    offer(2'd3, 8'd3);
    @(negedge CLK_in);
    cfg_valid = 1'b0;
    for (int i = 0; i < 400 && active_sel != 2'd3; i++) @(negedge CLK_in);
    check("prog_sel", active_sel, 3);
    lo = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_in);
      if (CLK_out) break;
      lo++;
    end
    check("prog_first_low", lo, 3);
    measure(hi, lo);
    check("prog_period", hi + lo, 6);

    // Async reset while pending with CLK_out high
    offer(2'd1, '0);
    @(negedge CLK_in);
    cfg_valid = 1'b0;
    check("ar_pend_ready", cfg_ready, 0);
    check("ar_pend_clk", CLK_out, 1);
    #2 RST = 1'b1;
    #1;
    check("ar_clk_out", CLK_out, 0);
    check("ar_busy", busy, 0);
    check("ar_active_sel", active_sel, 0);
    check("ar_cfg_ready", cfg_ready, 1);
    #1 RST = 1'b0;
    repeat (6) @(negedge CLK_in);
    check("ar_pend_lost", active_sel, 0);
    check("ar_restart_busy", busy, 1);

    // Randomized traffic
    repeat (4000) begin
      @(negedge CLK_in);
      if ($urandom_range(99) < 3) en = ~en;
      cfg_valid = ($urandom_range(99) < 8);
      cfg_sel = 2'($urandom_range(3));
      cfg_half = CNT_W'($urandom_range(4));
      if ($urandom_range(999) == 0) begin
        #2 RST = 1'b1;
        #1 RST = 1'b0;
      end
    end
    en = 1'b0;
    cfg_valid = 1'b0;
    repeat (5) @(negedge CLK_in);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
